// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg: state, opcode and datapath-select encodings shared by the multicycle RV32I control and immediate generator.
// Defining RV_CTRL_JUMP_EN adds JAL/JALR dispatch to the JUMP state.
package rv_ctrl_pkg;
  typedef enum logic [3:0] {
    ST_FETCH, ST_DECODE, ST_EXEC_R, ST_EXEC_I, ST_MEM_ADDR, ST_MEM_RD,
    ST_MEM_WR, ST_WB_ALU, ST_WB_MEM, ST_BRANCH, ST_JUMP, ST_ERROR
  } state_e;
  localparam int NS = 12;
  typedef logic [NS-1:0] state_t;
  localparam state_t S_FETCH    = state_t'(1) << ST_FETCH;
  localparam state_t S_DECODE   = state_t'(1) << ST_DECODE;
  localparam state_t S_EXEC_R   = state_t'(1) << ST_EXEC_R;
  localparam state_t S_EXEC_I   = state_t'(1) << ST_EXEC_I;
  localparam state_t S_MEM_ADDR = state_t'(1) << ST_MEM_ADDR;
  localparam state_t S_MEM_RD   = state_t'(1) << ST_MEM_RD;
  localparam state_t S_MEM_WR   = state_t'(1) << ST_MEM_WR;
  localparam state_t S_WB_ALU   = state_t'(1) << ST_WB_ALU;
  localparam state_t S_WB_MEM   = state_t'(1) << ST_WB_MEM;
  localparam state_t S_BRANCH   = state_t'(1) << ST_BRANCH;
  localparam state_t S_JUMP     = state_t'(1) << ST_JUMP;
  localparam state_t S_ERROR    = state_t'(1) << ST_ERROR;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [2:0] IMM_I     = 3'd0;
  localparam logic [2:0] IMM_S     = 3'd1;
  localparam logic [2:0] IMM_B     = 3'd2;
  localparam logic [2:0] IMM_SH    = 3'd3;
  localparam logic [2:0] IMM_J     = 3'd4;
  localparam logic [2:0] IMM_NONE  = 3'd7;
  localparam logic [1:0] SRCB_RS2  = 2'd0;
  localparam logic [1:0] SRCB_4    = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;
  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;
  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC4 = 2'd2;
`ifdef RV_CTRL_JUMP_EN
  localparam bit JUMP_EN = 1'b1;
`else
  localparam bit JUMP_EN = 1'b0;
`endif
  function automatic state_t dispatch(input logic [6:0] op);
    return op == OP_R ? S_EXEC_R :
           op == OP_IMM ? S_EXEC_I :
           (op == OP_LOAD || op == OP_STORE) ? S_MEM_ADDR :
           op == OP_BRANCH ? S_BRANCH :
           (JUMP_EN && (op == OP_JAL || op == OP_JALR)) ? S_JUMP : S_ERROR;
  endfunction
  function automatic logic [2:0] imm_format(input logic [6:0] op, input logic [2:0] f3);
    return op == OP_LOAD ? IMM_I :
           op == OP_STORE ? IMM_S :
           op == OP_BRANCH ? IMM_B :
           op == OP_IMM ? ((f3 == 3'b001 || f3 == 3'b101) ? IMM_SH : IMM_I) :
           (JUMP_EN && op == OP_JAL) ? IMM_J :
           (JUMP_EN && op == OP_JALR) ? IMM_I : IMM_NONE;
  endfunction
endpackage

// File: rtl/rv_mem_timeout.sv
// rv_mem_timeout: counts handshake-less cycles of a memory request; start holds it cleared while no request is pending.
module rv_mem_timeout #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic hit,
  output logic expired
);
  logic [7:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (start || hit) ? '0 : cnt + 8'd1;
  assign expired = !start && !hit && cnt == 8'(MEM_TIMEOUT - 1);
endmodule

// File: rtl/rv_multicycle_ctrl.sv
// rv_multicycle_ctrl: one-hot main control FSM of the multicycle RV32I core with unified memory port arbitration.
// JAL/JALR support is compiled in with RV_CTRL_JUMP_EN.
module rv_multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [2:0]       imm_sel,
  output logic [1:0]       wb_sel,
  output logic [CNT_W-1:0] retired,
  output logic             err
);
  state_t state, nxt;
  logic hs, expired, waiting, jump, take, unused;
  assign unused = funct7_5;
  assign jump = JUMP_EN && state[ST_JUMP];
  assign waiting = state[ST_FETCH] | state[ST_MEM_RD] | state[ST_MEM_WR];
  assign hs = mem_req & mem_ready;
  assign take = funct3 == 3'b000 ? alu_zero : funct3 == 3'b001 ? !alu_zero : 1'b0;
  rv_mem_timeout #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_tmo (
    .clk(clk), .rst_n(rst_n), .start(!waiting), .hit(hs), .expired(expired)
  );
  always_comb begin
    nxt = S_ERROR;
    case (1'b1)
      state[ST_FETCH]:    nxt = hs ? S_DECODE : expired ? S_ERROR : S_FETCH;
      state[ST_DECODE]:   nxt = dispatch(opcode);
      state[ST_EXEC_R]:   nxt = S_WB_ALU;
      state[ST_EXEC_I]:   nxt = S_WB_ALU;
      state[ST_MEM_ADDR]: nxt = opcode == OP_LOAD ? S_MEM_RD : S_MEM_WR;
      state[ST_MEM_RD]:   nxt = hs ? S_WB_MEM : expired ? S_ERROR : S_MEM_RD;
      state[ST_MEM_WR]:   nxt = hs ? S_FETCH : expired ? S_ERROR : S_MEM_WR;
      state[ST_WB_ALU]:   nxt = S_FETCH;
      state[ST_WB_MEM]:   nxt = S_FETCH;
      state[ST_BRANCH]:   nxt = funct3[2:1] == 2'b00 ? S_FETCH : S_ERROR;
      state[ST_JUMP]:     nxt = JUMP_EN ? S_FETCH : S_ERROR;
      default:            nxt = S_ERROR;
    endcase
  end
  // every path back into FETCH is a retirement; ERROR never reaches it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_FETCH;
      retired <= '0;
    end else begin
      state <= nxt;
      if (!state[ST_FETCH] && nxt[ST_FETCH]) retired <= retired + CNT_W'(1);
    end
  // rst_n gating keeps every output quiet while reset is held
  assign mem_req = rst_n & waiting;
  assign mem_we = rst_n & state[ST_MEM_WR];
  assign iord = rst_n & (state[ST_MEM_RD] | state[ST_MEM_WR]);
  assign ir_write = state[ST_FETCH] & hs;
  assign pc_write = ir_write | (rst_n & ((state[ST_BRANCH] & take) | jump));
  assign reg_write = rst_n & (state[ST_WB_ALU] | state[ST_WB_MEM] | jump);
  assign alu_src_a = rst_n & (state[ST_EXEC_R] | state[ST_EXEC_I] | state[ST_MEM_ADDR] |
                              state[ST_BRANCH] | (jump & opcode == OP_JALR));
  assign alu_src_b = !rst_n ? SRCB_RS2 : state[ST_FETCH] ? SRCB_4 :
                     (state[ST_DECODE] | state[ST_EXEC_I] | state[ST_MEM_ADDR] | jump) ? SRCB_IMM : SRCB_RS2;
  assign alu_op = !rst_n ? ALU_ADD : (state[ST_EXEC_R] | state[ST_EXEC_I]) ? ALU_FUNCT :
                  state[ST_BRANCH] ? ALU_SUB : ALU_ADD;
  assign wb_sel = !rst_n ? WB_SEL_ALU : state[ST_WB_MEM] ? WB_SEL_MEM : jump ? WB_SEL_PC4 : WB_SEL_ALU;
  assign imm_sel = (!rst_n || state[ST_FETCH] || state[ST_ERROR]) ? IMM_NONE : imm_format(opcode, funct3);
  assign err = state[ST_ERROR];
endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// tb_rv_multicycle_ctrl: directed instruction sequences with hand-computed control outputs (MEM_TIMEOUT=4, CNT_W=3).
module tb_rv_multicycle_ctrl;
  logic clk = 1'b0;
  logic rst_n, funct7_5, alu_zero, mem_ready;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic mem_req, mem_we, iord, ir_write, pc_write, reg_write, alu_src_a, err;
  logic [1:0] alu_src_b, alu_op, wb_sel;
  logic [2:0] imm_sel;
  logic [2:0] retired;
  int n_chk = 0;
  int n_pass = 0;
  always #5 clk = ~clk;
  rv_multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .alu_zero(alu_zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .iord(iord), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .imm_sel(imm_sel),
    .wb_sel(wb_sel), .retired(retired), .err(err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic cy(input logic rdy);
    @(negedge clk);
    mem_ready = rdy;
    #1;
  endtask
  task automatic instr(input logic [6:0] op, input logic [2:0] f3, input logic rdy);
    @(negedge clk);
    opcode = op;
    funct3 = f3;
    mem_ready = rdy;
    #1;
  endtask
  task automatic rel();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  initial begin
    rst_n = 1'b0; mem_ready = 1'b0; opcode = '0; funct3 = '0; funct7_5 = 1'b0; alu_zero = 1'b1;
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_imm_sel", imm_sel, 7);
    chk("rst_alu_src_b", alu_src_b, 0);
    chk("rst_retired", retired, 0);
    chk("rst_err", err, 0);
    rel();
    instr(7'b0110011, 3'b000, 1'b1);
    chk("add_ir_write", ir_write, 1);
    chk("add_pc_write", pc_write, 1);
    chk("add_fetch_srcb", alu_src_b, 1);
    chk("add_fetch_iord", iord, 0);
    cy(0);
    chk("add_dec_req", mem_req, 0);
    chk("add_dec_rw", reg_write, 0);
    cy(0);
    chk("add_ex_op", alu_op, 2);
    chk("add_ex_srca", alu_src_a, 1);
    chk("add_ex_srcb", alu_src_b, 0);
    cy(0);
    chk("add_wb_rw", reg_write, 1);
    chk("add_wb_sel", wb_sel, 0);
    chk("add_wb_retired", retired, 0);
    instr(7'b0000011, 3'b010, 1'b1);
    chk("lw_retired", retired, 1);
    chk("lw_ir_write", ir_write, 1);
    cy(0);
    chk("lw_dec_imm", imm_sel, 0);
    cy(0);
    chk("lw_addr_srcb", alu_src_b, 2);
    chk("lw_addr_srca", alu_src_a, 1);
    chk("lw_addr_req", mem_req, 0);
    for (int i = 0; i < 3; i++) begin
      cy(0);
      chk("lw_wait_req", mem_req, 1);
      chk("lw_wait_iord", iord, 1);
    end
    cy(1);
    chk("lw_hs_req", mem_req, 1);
    chk("lw_hs_iord", iord, 1);
    chk("lw_hs_irw", ir_write, 0);
    cy(0);
    chk("lw_wb_rw", reg_write, 1);
    chk("lw_wb_sel", wb_sel, 1);
    chk("lw_wb_imm", imm_sel, 0);
    chk("lw_wb_req", mem_req, 0);
    instr(7'b0100011, 3'b010, 1'b1);
    chk("sw_retired", retired, 2);
    cy(0);
    chk("sw_dec_imm", imm_sel, 1);
    cy(0);
    cy(1);
    chk("sw_we", mem_we, 1);
    chk("sw_req", mem_req, 1);
    chk("sw_iord", iord, 1);
    instr(7'b1100011, 3'b000, 1'b1);
    chk("beq_retired", retired, 3);
    cy(0);
    chk("beq_dec_imm", imm_sel, 2);
    cy(0);
    chk("beq_pc_write", pc_write, 1);
    chk("beq_alu_op", alu_op, 1);
    chk("beq_imm", imm_sel, 2);
    instr(7'b1100011, 3'b001, 1'b1);
    chk("bne_retired", retired, 4);
    cy(0);
    chk("bne_dec_imm", imm_sel, 2);
    cy(0);
    chk("bne_pc_write", pc_write, 0);
    chk("bne_imm", imm_sel, 2);
    instr(7'b0010011, 3'b001, 1'b1);
    chk("slli_retired", retired, 5);
    cy(0);
    chk("slli_imm", imm_sel, 3);
    cy(0);
    chk("slli_op", alu_op, 2);
    chk("slli_srcb", alu_src_b, 2);
    cy(0);
    chk("slli_rw", reg_write, 1);
    instr(7'b0010011, 3'b000, 1'b1);
    chk("addi_retired", retired, 6);
    cy(1);
    chk("addi_imm", imm_sel, 0);
    chk("addi_stray_ready_irw", ir_write, 0);
    chk("addi_dec_req", mem_req, 0);
    cy(1);
    chk("addi_ex_op", alu_op, 2);
    cy(1);
    chk("addi_rw", reg_write, 1);
    instr(7'b0010011, 3'b000, 1'b0);
    chk("tmo_edge_retired", retired, 7);
    cy(0);
    cy(0);
    cy(1);
    chk("tmo_edge_irw", ir_write, 1);
    chk("tmo_edge_req", mem_req, 1);
    cy(0);
    chk("tmo_edge_err", err, 0);
    chk("tmo_edge_dec_imm", imm_sel, 0);
    cy(0);
    cy(0);
    chk("tmo_edge_rw", reg_write, 1);
    instr(7'b0010011, 3'b000, 1'b1);
    chk("retired_wrap", retired, 0);
    cy(0);
    cy(0);
    cy(0);
    instr(7'b0100011, 3'b010, 1'b1);
    chk("pre_rst_retired", retired, 1);
    cy(0);
    cy(0);
    cy(0);
    chk("mid_wr_we", mem_we, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", mem_we, 0);
    chk("mid_rst_req", mem_req, 0);
    chk("mid_rst_retired", retired, 0);
    rel();
    for (int i = 0; i < 4; i++) begin
      cy(0);
      chk("tmo_wait_req", mem_req, 1);
      chk("tmo_wait_err", err, 0);
    end
    cy(1);
    chk("tmo_err", err, 1);
    chk("tmo_req", mem_req, 0);
    chk("tmo_irw", ir_write, 0);
    chk("tmo_imm", imm_sel, 7);
    rst_n = 1'b0;
    #1;
    rel();
    instr(7'h7F, 3'b000, 1'b1);
    chk("ill_irw", ir_write, 1);
    cy(0);
    chk("ill_dec_imm", imm_sel, 7);
    cy(0);
    chk("ill_err", err, 1);
    chk("ill_rw", reg_write, 0);
    rst_n = 1'b0;
    #1;
    rel();
    instr(7'b1101111, 3'b000, 1'b1);
    cy(0);
`ifdef RV_CTRL_JUMP_EN
    chk("jal_dec_imm", imm_sel, 4);
    cy(0);
    chk("jal_rw", reg_write, 1);
    chk("jal_wb_sel", wb_sel, 2);
    chk("jal_pc_write", pc_write, 1);
    chk("jal_err", err, 0);
    cy(0);
    chk("jal_retired", retired, 1);
    chk("jal_fetch_req", mem_req, 1);
`else
    chk("jal_dec_imm", imm_sel, 7);
    cy(0);
    chk("jal_err", err, 1);
    chk("jal_rw", reg_write, 0);
    chk("jal_wb_sel", wb_sel, 0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
